// File: rtl/bram_pkg.sv
// bram_pkg: shared constants, FSM encoding and lane-mask helper
// for the bram_pipe_clr block RAM family.
package bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int MAX_DW    = 256;
  localparam int MAX_LANES = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Expands one enable bit per lane into a per-bit mask; callers
  // truncate the result to their own data width.
  function automatic logic [MAX_DW-1:0] lane_mask(
    input logic [MAX_LANES-1:0] wbe,
    input int                   lw
  );
    logic [MAX_DW-1:0] m;
    int                lane;
    m = '0;
    for (int b = 0; b < MAX_DW; b++) begin
      lane = (lw > 0) ? (b / lw) : MAX_LANES;
      if (lane < MAX_LANES)
        m[b] = wbe[lane[4:0]];
    end
    return m;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// bram_rd_pipe: data+valid delay line of DEPTH stages, reset to zero.
// DEPTH of zero is a straight wire.
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid
);

  if (DEPTH == 0) begin : g_thru

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_data  = in_data;
    assign out_valid = in_valid;

  end else begin : g_pipe

    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    always_comb begin
      data_d[0] = in_data;
      vld_d     = '0;
      vld_d[0]  = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++)
          data_q[i] <= '0;
        vld_q <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];

  end

endmodule

// File: rtl/bram_pipe_clr.sv
// bram_pipe_clr: simple dual-port block RAM with lane write enables,
// 1/2-cycle read latency, read-during-write policy and clear sweep.
module bram_pipe_clr
  import bram_pkg::*;
#(
  parameter int N_ADDR       = 256,
  parameter int DATA_WIDTH   = 16,
  parameter int N_LANES      = 2,
  parameter int RD_LATENCY   = 1,
  parameter int RDW_FWD      = RDW_READ_FIRST,
  parameter int CLEAR_ON_RST = 1,
  localparam int AW = (N_ADDR > 1) ? $clog2(N_ADDR) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [N_LANES-1:0]    wbe,
  input  logic [AW-1:0]         wadd,
  input  logic [DATA_WIDTH-1:0] win,
  input  logic                  ren,
  input  logic [AW-1:0]         radd,
  output logic [DATA_WIDTH-1:0] wout,
  output logic                  wout_valid,
  output logic                  busy
);

  localparam int              LW    = DATA_WIDTH / N_LANES;
  localparam logic [AW:0]     DEPTH = (AW+1)'(N_ADDR);
  localparam logic [AW-1:0]   LAST  = AW'(N_ADDR - 1);
  localparam state_e          RST_ST =
    (CLEAR_ON_RST != 0) ? CLEAR : IDLE;

  logic [DATA_WIDTH-1:0] mem [N_ADDR];

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;

  logic                  idle;
  logic                  wr_ok, rd_ok;
  logic                  wr_fire, rd_fire;
  logic                  collide;
  logic [DATA_WIDTH-1:0] wmask;

  logic                  mem_we;
  logic [AW-1:0]         mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [N_LANES-1:0]    mem_be;

  logic [DATA_WIDTH-1:0] ram_q;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_oor_q, rd_oor_d;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [DATA_WIDTH-1:0] fwd_mask_q, fwd_mask_d;
  logic [DATA_WIDTH-1:0] s1_data;

  assign wmask = DATA_WIDTH'(lane_mask(MAX_LANES'(wbe), LW));

  always_comb begin
    idle    = (state_q == IDLE);
    wr_ok   = ({1'b0, wadd} < DEPTH);
    rd_ok   = ({1'b0, radd} < DEPTH);
    wr_fire = idle && wen && wr_ok && !rst;
    rd_fire = idle && ren && !rst;
    collide = wr_fire && rd_fire && (wadd == radd)
              && (RDW_FWD == RDW_WRITE_FIRST);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep owns the write port; user writes only reach it when idle.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wadd;
    mem_wd = win;
    mem_be = wbe;
    if (!rst && state_q == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
      mem_be = '1;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < N_LANES; k++)
        if (mem_be[k])
          mem[mem_wa][k*LW +: LW] <= mem_wd[k*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ram_q <= '0;
    else if (rd_fire && rd_ok)
      ram_q <= mem[radd];
  end

  // Qualifiers only move on an accepted read so the output holds.
  always_comb begin
    rd_vld_d   = rd_fire;
    rd_oor_d   = rd_oor_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    fwd_mask_d = fwd_mask_q;
    if (rd_fire) begin
      rd_oor_d   = !rd_ok;
      fwd_d      = collide;
      fwd_data_d = win;
      fwd_mask_d = wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
    end else begin
      rd_vld_q   <= rd_vld_d;
      rd_oor_q   <= rd_oor_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      fwd_mask_q <= fwd_mask_d;
    end
  end

  always_comb begin
    s1_data = ram_q;
    if (rd_oor_q)
      s1_data = '0;
    else if (fwd_q)
      s1_data = (fwd_data_q & fwd_mask_q) | (ram_q & ~fwd_mask_q);
  end

  bram_rd_pipe #(
    .DW    (DATA_WIDTH),
    .DEPTH (RD_LATENCY - 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_data   (s1_data),
    .in_valid  (rd_vld_q),
    .out_data  (wout),
    .out_valid (wout_valid)
  );

  assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_bram_pipe_clr.sv
// tb_bram_pipe_clr: three configurations driven in lockstep, each
// checked every cycle against a word-level behavioural model.
module tb_bram_pipe_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [1:0]  wbe = 2'b00;
  logic [7:0]  wadd = '0;
  logic [7:0]  radd = '0;
  logic [15:0] win = '0;

  logic [15:0] wo [3];
  logic        wv [3];
  logic        bs [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_pipe_clr #(.N_ADDR(256), .RD_LATENCY(1), .RDW_FWD(0)) u0 (
    .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .wadd(wadd),
    .win(win), .ren(ren), .radd(radd), .wout(wo[0]),
    .wout_valid(wv[0]), .busy(bs[0]));

  bram_pipe_clr #(.N_ADDR(256), .RD_LATENCY(2), .RDW_FWD(1)) u1 (
    .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .wadd(wadd),
    .win(win), .ren(ren), .radd(radd), .wout(wo[1]),
    .wout_valid(wv[1]), .busy(bs[1]));

  bram_pipe_clr #(.N_ADDR(200), .RD_LATENCY(1), .RDW_FWD(0)) u2 (
    .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .wadd(wadd),
    .win(win), .ren(ren), .radd(radd), .wout(wo[2]),
    .wout_valid(wv[2]), .busy(bs[2]));

  int NA [3] = '{256, 256, 200};
  int LT [3] = '{1, 2, 1};
  bit FW [3] = '{1'b0, 1'b1, 1'b0};

  logic [15:0] mm [3][256];
  bit          sv [3][4];
  logic [15:0] sd [3][4];
  logic [15:0] ew [3];
  bit          ev [3];
  int          bl [3];
  int          cyc = 0;
  bit          inited = 1'b0;

  // Model: memory reads as zero once reset is seen (no reads escape
  // while busy); read results are scheduled LT cycles ahead.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] d;
      int          s;
      bit          bz;
      if (rst) begin
        bl[i] = NA[i];
        ew[i] = '0;
        ev[i] = 1'b0;
        for (int a = 0; a < 256; a++) mm[i][a] = '0;
        for (int q = 0; q < 4; q++) sv[i][q] = 1'b0;
      end else begin
        bz = (bl[i] > 0);
        if (!bz && ren) begin
          if (int'(radd) >= NA[i]) begin
            d = '0;
          end else begin
            d = mm[i][radd];
            if (FW[i] && wen && wadd == radd)
              for (int k = 0; k < 2; k++)
                if (wbe[k]) d[k*8 +: 8] = win[k*8 +: 8];
          end
          s = (cyc + LT[i] - 1) % 4;
          sv[i][s] = 1'b1;
          sd[i][s] = d;
        end
        if (!bz && wen && int'(wadd) < NA[i])
          for (int k = 0; k < 2; k++)
            if (wbe[k]) mm[i][wadd][k*8 +: 8] = win[k*8 +: 8];
        if (bz) bl[i] = bl[i] - 1;
        s = cyc % 4;
        ev[i] = sv[i][s];
        if (sv[i][s]) ew[i] = sd[i][s];
        sv[i][s] = 1'b0;
      end
    end
    if (rst) inited = 1'b1;
  end

  task automatic run_compare();
    forever begin
      @(negedge clk);
      if (inited) begin
        for (int i = 0; i < 3; i++) begin
          tests = tests + 3;
          if (bs[i] !== (bl[i] > 0)) begin
            fails++;
            $display("FAIL u%0d busy @%0d: got %b want %b",
                     i, cyc, bs[i], (bl[i] > 0));
          end
          if (wv[i] !== ev[i]) begin
            fails++;
            $display("FAIL u%0d wout_valid @%0d: got %b want %b",
                     i, cyc, wv[i], ev[i]);
          end
          if (wo[i] !== ew[i]) begin
            fails++;
            $display("FAIL u%0d wout @%0d: got %h want %h",
                     i, cyc, wo[i], ew[i]);
          end
        end
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d,
                    input logic [1:0] be);
    wen = 1'b1; wadd = a; win = d; wbe = be;
    @(negedge clk);
    wen = 1'b0; wbe = 2'b00;
  endtask

  task automatic wait_busy(output int n, inout int nv);
    n = 0;
    while (bs[0] === 1'b1 && n < 1000) begin
      if (wv[0] === 1'b1) nv++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 256; a++) begin
      ren = 1'b1; radd = 8'(a);
      @(negedge clk);
    end
    ren = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 8'(r);
    return 8'($urandom_range(195, 255));
  endfunction

  initial begin
    int n;
    int nv;
    fork
      run_compare();
    join_none
    @(negedge clk);

    // sweep length and all-zero contents
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    nv = 0;
    wait_busy(n, nv);
    check("sweep_len", n, 256);
    read_all();

    // lane merge
    wr(8'd5, 16'hBEEF, 2'b01);
    wr(8'd5, 16'h1234, 2'b10);
    ren = 1'b1; radd = 8'd5; @(negedge clk); ren = 1'b0;
    check("merge_u0", wo[0], 16'h12EF);
    check("merge_u0_v", wv[0], 1);
    @(negedge clk);
    check("merge_u1", wo[1], 16'h12EF);

    // back-to-back reads, latency 1 vs 2
    wr(8'd1, 16'h1111, 2'b11);
    wr(8'd2, 16'h2222, 2'b11);
    wr(8'd3, 16'h3333, 2'b11);
    ren = 1'b1; radd = 8'd1; @(negedge clk);
    check("b2b_u0_d1", wo[0], 16'h1111);
    check("b2b_u1_v0", wv[1], 0);
    radd = 8'd2; @(negedge clk);
    check("b2b_u0_d2", wo[0], 16'h2222);
    check("b2b_u1_d1", wo[1], 16'h1111);
    radd = 8'd3; @(negedge clk);
    check("b2b_u1_d2", wo[1], 16'h2222);
    ren = 1'b0; @(negedge clk);
    check("b2b_u0_hold", wo[0], 16'h3333);
    check("b2b_u0_v", wv[0], 0);
    check("b2b_u1_d3", wo[1], 16'h3333);
    @(negedge clk);
    check("b2b_u1_v", wv[1], 0);

    // read-during-write collision
    wr(8'd7, 16'h0001, 2'b11);
    wen = 1'b1; wadd = 8'd7; win = 16'hAAAA; wbe = 2'b11;
    ren = 1'b1; radd = 8'd7; @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    check("rdw_u0_old", wo[0], 16'h0001);
    check("rdw_u2_old", wo[2], 16'h0001);
    @(negedge clk);
    check("rdw_u1_new", wo[1], 16'hAAAA);
    wen = 1'b1; wadd = 8'd7; win = 16'h5555; wbe = 2'b01;
    ren = 1'b1; radd = 8'd7; @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    check("rdw_u0_part", wo[0], 16'hAAAA);
    @(negedge clk);
    check("rdw_u1_part", wo[1], 16'hAA55);

    // reset mid-sweep; traffic while busy is ignored
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    ren = 1'b1; radd = 8'd4;
    wen = 1'b1; wadd = 8'd9; win = 16'hFFFF; wbe = 2'b11;
    nv = 0;
    for (int c = 0; c < 99; c++) begin
      if (wv[0] === 1'b1) nv++;
      @(negedge clk);
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    wait_busy(n, nv);
    wen = 1'b0; ren = 1'b0; wbe = 2'b00;
    check("restart_len", n, 256);
    check("busy_no_valid", nv, 0);
    ren = 1'b1; radd = 8'd9; @(negedge clk); ren = 1'b0;
    check("busy_wr_lost", wo[0], 16'h0000);

    // out-of-range access on the 200-word instance
    wr(8'd210, 16'h7777, 2'b11);
    ren = 1'b1; radd = 8'd210; @(negedge clk); ren = 1'b0;
    check("oor_u2_data", wo[2], 16'h0000);
    check("oor_u2_valid", wv[2], 1);
    check("oor_u0_data", wo[0], 16'h7777);
    read_all();

    // mixed traffic with frequent collisions
    for (int c = 0; c < 400; c++) begin
      wen  = 1'($urandom_range(0, 1));
      ren  = 1'($urandom_range(0, 1));
      wbe  = 2'($urandom_range(0, 3));
      win  = 16'($urandom);
      wadd = pick();
      radd = ($urandom_range(0, 2) == 0) ? wadd : pick();
      @(negedge clk);
    end
    wen = 1'b0; ren = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
